// File: rtl/oerv_wdata_pack_pkg.sv
// Shared definitions for the serial store/load data paths: FSM encodings, store
// sizes and the store-word lane replication helper.
package oerv_wdata_pack_pkg;

    localparam int unsigned W     = 8;
    localparam int unsigned BEATS = 32 / W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_BUS     = 2'b10
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Replicate the low byte/half across the word so any lane picked by sel sees it.
    function automatic logic [31:0] pack_word(input logic [1:0] size, input logic [31:0] raw);
        case (size)
            SIZE_BYTE:        pack_word = {4{raw[7:0]}};
            SIZE_HALF:        pack_word = {2{raw[15:0]}};
            SIZE_WORD, 2'b11: pack_word = raw;
        endcase
    endfunction

endpackage

// File: rtl/oerv_lane_sel.sv
// Byte-enable and misalignment decode from access size and low address bits.
// Purely combinational; shared by the store packer and the load lane extractor.
module oerv_lane_sel
    import oerv_wdata_pack_pkg::*;
(
    input  logic [1:0] i_size,
    input  logic [1:0] i_adr_lo,
    output logic [3:0] o_sel,
    output logic       o_misalign
);

    always_comb begin
        o_sel      = 4'b1111;
        o_misalign = 1'b0;
        case (i_size)
            SIZE_BYTE: o_sel = 4'b0001 << i_adr_lo;
            SIZE_HALF: begin
                o_sel      = i_adr_lo[1] ? 4'b1100 : 4'b0011;
                o_misalign = i_adr_lo[0];
            end
            SIZE_WORD, 2'b11: o_misalign = |i_adr_lo;
        endcase
    end

endmodule

// File: rtl/oerv_wdata_pack.sv
// Collects four LSB-first 8-bit chunks into a 32-bit store word and issues a
// single classic Wishbone write; misaligned stores are rejected with a pulse.
module oerv_wdata_pack
    import oerv_wdata_pack_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_cnt_en,
    input  logic [W-1:0] i_dat,
    input  logic [1:0]   i_size,
    input  logic [31:0]  i_adr,
    output logic         o_busy,
    output logic         o_dbus_cyc,
    output logic         o_dbus_we,
    output logic [31:0]  o_dbus_adr,
    output logic [31:0]  o_dbus_dat,
    output logic [3:0]   o_dbus_sel,
    input  logic         i_dbus_ack,
    output logic         o_done,
    output logic         o_misalign
);

    state_e                    state_q;
    logic [1:0]                cnt_q;
    logic [BEATS-2:0][W-1:0]   beat_q;
    logic [31:0]               adr_q;
    logic [1:0]                size_q;

    logic [3:0]                sel_c;
    logic                      misalign_c;
    logic [31:0]               word_c;

    oerv_lane_sel u_lane_sel (
        .i_size     (size_q),
        .i_adr_lo   (adr_q[1:0]),
        .o_sel      (sel_c),
        .o_misalign (misalign_c)
    );

    // Beat 3 is never stored: it goes straight from i_dat into the output word.
    always_comb word_c = {i_dat, beat_q[2], beat_q[1], beat_q[0]};

    always_comb begin
        o_busy    = (state_q != ST_IDLE);
        o_dbus_we = o_dbus_cyc;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            beat_q     <= '0;
            adr_q      <= 32'd0;
            size_q     <= SIZE_BYTE;
            o_dbus_cyc <= 1'b0;
            o_dbus_adr <= 32'd0;
            o_dbus_dat <= 32'd0;
            o_dbus_sel <= 4'd0;
            o_done     <= 1'b0;
            o_misalign <= 1'b0;
        end else begin
            o_done     <= 1'b0;
            o_misalign <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        adr_q   <= i_adr;
                        size_q  <= i_size;
                        cnt_q   <= 2'd0;
                        state_q <= ST_COLLECT;
                        if (i_cnt_en) begin
                            beat_q[0] <= i_dat;
                            cnt_q     <= 2'd1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (i_cnt_en) begin
                        cnt_q <= cnt_q + 2'd1;
                        unique case (cnt_q)
                            2'd0: beat_q[0] <= i_dat;
                            2'd1: beat_q[1] <= i_dat;
                            2'd2: beat_q[2] <= i_dat;
                            2'd3: begin
                                if (misalign_c) begin
                                    o_misalign <= 1'b1;
                                    state_q    <= ST_IDLE;
                                end else begin
                                    o_dbus_cyc <= 1'b1;
                                    o_dbus_adr <= {adr_q[31:2], 2'b00};
                                    o_dbus_dat <= pack_word(size_q, word_c);
                                    o_dbus_sel <= sel_c;
                                    state_q    <= ST_BUS;
                                end
                            end
                        endcase
                    end
                end
                ST_BUS: begin
                    if (i_dbus_ack) begin
                        o_dbus_cyc <= 1'b0;
                        o_done     <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oerv_wdata_pack.sv
// Directed and randomized store sequences for oerv_wdata_pack, checked against a
// word-level model of store packing, byte enables and alignment.
module tb_oerv_wdata_pack;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic        i_cnt_en;
    logic [7:0]  i_dat;
    logic [1:0]  i_size;
    logic [31:0] i_adr;
    logic        o_busy;
    logic        o_dbus_cyc;
    logic        o_dbus_we;
    logic [31:0] o_dbus_adr;
    logic [31:0] o_dbus_dat;
    logic [3:0]  o_dbus_sel;
    logic        i_dbus_ack;
    logic        o_done;
    logic        o_misalign;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    logic [31:0] last_dat;
    logic [31:0] last_adr;
    logic [3:0]  last_sel;

    oerv_wdata_pack dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_cnt_en   (i_cnt_en),
        .i_dat      (i_dat),
        .i_size     (i_size),
        .i_adr      (i_adr),
        .o_busy     (o_busy),
        .o_dbus_cyc (o_dbus_cyc),
        .o_dbus_we  (o_dbus_we),
        .o_dbus_adr (o_dbus_adr),
        .o_dbus_dat (o_dbus_dat),
        .o_dbus_sel (o_dbus_sel),
        .i_dbus_ack (i_dbus_ack),
        .o_done     (o_done),
        .o_misalign (o_misalign)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) if (o_done) n_done++;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: stores expressed as arithmetic on the byte address and size.
    function automatic logic [31:0] model_dat(input logic [1:0] size, input logic [31:0] raw);
        if (size == 2'd0)      return 32'(raw[7:0]) * 32'h0101_0101;
        else if (size == 2'd1) return 32'(raw[15:0]) * 32'h0001_0001;
        else                   return raw;
    endfunction

    function automatic logic [3:0] model_sel(input logic [1:0] size, input logic [31:0] adr);
        int unsigned off = adr % 4;
        if (size == 2'd0)      return 4'(32'd1 << off);
        else if (size == 2'd1) return (off >= 2) ? 4'd12 : 4'd3;
        else                   return 4'd15;
    endfunction

    function automatic bit model_mis(input logic [1:0] size, input logic [31:0] adr);
        if (size == 2'd0)      return 1'b0;
        else if (size == 2'd1) return (adr % 2) != 0;
        else                   return (adr % 4) != 0;
    endfunction

    task automatic run_store(input logic [31:0] adr, input logic [1:0] size,
                             input logic [31:0] raw, input bit gap, input int ack_dly,
                             input bit spurious, input bit rst_in_bus);
        logic [31:0] exp_dat;
        logic [31:0] exp_adr;
        logic [3:0]  exp_sel;
        bit          mis;
        int          done0;
        exp_dat = model_dat(size, raw);
        exp_sel = model_sel(size, adr);
        exp_adr = adr - (adr % 4);
        mis     = model_mis(size, adr);
        done0   = n_done;

        i_adr = adr; i_size = size; i_start = 1'b1; i_cnt_en = 1'b1; i_dat = raw[7:0];
        step();
        i_start = 1'b0;
        for (int k = 1; k < 4; k++) begin
            if (gap) begin
                i_cnt_en = 1'b0;
                i_dat    = 8'($urandom);
                if (spurious) begin
                    i_start = 1'b1; i_adr = $urandom; i_size = 2'($urandom);
                end
                step();
                i_start = 1'b0;
                check("gap_busy", 32'(o_busy), 32'd1);
                check("gap_cyc", 32'(o_dbus_cyc), 32'd0);
            end
            i_cnt_en = 1'b1;
            i_dat    = raw[8*k +: 8];
            step();
        end
        i_cnt_en = 1'b0;

        if (mis) begin
            check("mis_pulse", 32'(o_misalign), 32'd1);
            check("mis_cyc", 32'(o_dbus_cyc), 32'd0);
            check("mis_busy", 32'(o_busy), 32'd0);
            check("mis_dat_hold", o_dbus_dat, last_dat);
            step();
            check("mis_pulse_end", 32'(o_misalign), 32'd0);
            check("mis_cyc_after", 32'(o_dbus_cyc), 32'd0);
            return;
        end

        check("bus_cyc", 32'(o_dbus_cyc), 32'd1);
        check("bus_we", 32'(o_dbus_we), 32'd1);
        check("bus_adr", o_dbus_adr, exp_adr);
        check("bus_dat", o_dbus_dat, exp_dat);
        check("bus_sel", 32'(o_dbus_sel), 32'(exp_sel));
        check("bus_no_mis", 32'(o_misalign), 32'd0);

        if (rst_in_bus) begin
            #2 i_rst = 1'b1;
            #1;
            check("rst_cyc_async", 32'(o_dbus_cyc), 32'd0);
            check("rst_busy", 32'(o_busy), 32'd0);
            i_dbus_ack = 1'b1;
            step();
            step();
            i_dbus_ack = 1'b0;
            i_rst = 1'b0;
            step();
            check("rst_no_done", 32'(n_done - done0), 32'd0);
            check("rst_dat_zero", o_dbus_dat, 32'd0);
            last_dat = 32'd0; last_adr = 32'd0; last_sel = 4'd0;
            return;
        end

        for (int i = 0; i < ack_dly; i++) begin
            i_cnt_en = 1'($urandom);
            step();
            check("hold_cyc", 32'(o_dbus_cyc), 32'd1);
            check("hold_dat", o_dbus_dat, exp_dat);
            check("hold_sel", 32'(o_dbus_sel), 32'(exp_sel));
            check("hold_adr", o_dbus_adr, exp_adr);
        end
        i_cnt_en   = 1'b0;
        i_dbus_ack = 1'b1;
        step();
        i_dbus_ack = 1'b0;
        check("ack_cyc_low", 32'(o_dbus_cyc), 32'd0);
        check("ack_done", 32'(o_done), 32'd1);
        check("ack_busy", 32'(o_busy), 32'd0);
        step();
        check("done_pulse_end", 32'(o_done), 32'd0);
        check("done_count", 32'(n_done - done0), 32'd1);
        check("idle_dat_hold", o_dbus_dat, exp_dat);
        last_dat = exp_dat; last_adr = exp_adr; last_sel = exp_sel;
    endtask

    task automatic idle_noise();
        int done0;
        done0 = n_done;
        i_dbus_ack = 1'b1; i_cnt_en = 1'b1; i_dat = 8'($urandom);
        step();
        i_dbus_ack = 1'b0; i_cnt_en = 1'b0;
        step();
        check("idle_busy", 32'(o_busy), 32'd0);
        check("idle_cyc", 32'(o_dbus_cyc), 32'd0);
        check("idle_no_done", 32'(n_done - done0), 32'd0);
        check("idle_dat", o_dbus_dat, last_dat);
        check("idle_sel", 32'(o_dbus_sel), 32'(last_sel));
        check("idle_adr", o_dbus_adr, last_adr);
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_cnt_en = 1'b0; i_dat = 8'd0;
        i_size = 2'd0; i_adr = 32'd0; i_dbus_ack = 1'b0;
        last_dat = 32'd0; last_adr = 32'd0; last_sel = 4'd0;
        step();
        step();
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_cyc", 32'(o_dbus_cyc), 32'd0);
        check("rst_dat", o_dbus_dat, 32'd0);
        check("rst_adr", o_dbus_adr, 32'd0);
        check("rst_sel", 32'(o_dbus_sel), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        i_rst = 1'b0;
        step();

        run_store(32'h100, 2'b10, 32'h1234_5678, 1'b0, 1, 1'b0, 1'b0);
        run_store(32'h203, 2'b00, {8'($urandom), 8'($urandom), 8'($urandom), 8'hAB},
                  1'b0, 0, 1'b0, 1'b0);
        run_store(32'h301, 2'b01, $urandom, 1'b0, 0, 1'b0, 1'b0);
        run_store(32'h402, 2'b10, $urandom, 1'b0, 0, 1'b0, 1'b0);
        run_store(32'h502, 2'b01, 32'h0000_BEEF, 1'b1, 5, 1'b0, 1'b0);
        run_store(32'h604, 2'b11, 32'hCAFE_F00D, 1'b1, 2, 1'b1, 1'b0);
        idle_noise();
        run_store(32'h700, 2'b10, $urandom, 1'b0, 3, 1'b0, 1'b1);
        run_store(32'h804, 2'b10, 32'hA5A5_0F0F, 1'b0, 0, 1'b0, 1'b0);
        idle_noise();

        for (int t = 0; t < 40; t++) begin
            logic [31:0] adr;
            adr = $urandom;
            if ($urandom_range(0, 1) == 0) adr[1:0] = 2'b00;
            run_store(adr, 2'($urandom), $urandom, 1'($urandom),
                      int'($urandom_range(0, 5)), 1'($urandom), 1'b0);
            if (t % 8 == 7) idle_noise();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
